// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate response checkers.
package gate_chk_pkg;

    // Run-control states of the checker.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_t;

    // Golden operation selectors.
    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_NAND = 2'd3;

endpackage

// File: rtl/gate_golden_model.sv
// Combinational reference model: produces the expected result of a bitwise
// gate operation over WIDTH bits.
module gate_golden_model
    import gate_chk_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [1:0]       op_sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] expected_o
);

    // Select the golden operation.
    always_comb begin
        expected_o = '0;
        case (op_sel_i)
            OP_AND:  expected_o = a_i & b_i;
            OP_OR:   expected_o = a_i | b_i;
            OP_XOR:  expected_o = a_i ^ b_i;
            OP_NAND: expected_o = ~(a_i & b_i);
            default: expected_o = '0;
        endcase
    end

endmodule

// File: rtl/gate_response_checker.sv
// Checks {A,B,Result} vectors against a golden gate op, counting samples and
// mismatches (saturating) and tracking which {A[0],B[0]} combos were seen.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int OP_SEL      = 0,
    parameter int MIN_SAMPLES = 4,
    parameter int CNT_W       = 8,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [3:0]       coverage
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // One extra bit so a MIN_SAMPLES equal to 2**CNT_W is still representable.
    localparam logic [CNT_W:0]   MIN_CMP = (CNT_W + 1)'(MIN_SAMPLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [3:0]       coverage_q, coverage_d;
    logic             err_flag_q, err_flag_d;

    logic [WIDTH-1:0] expected;
    logic             accept;
    logic             mismatch;
    logic             exit_ok;
    logic             clear;
    logic [1:0]       combo;
    logic [3:0]       cov_hit;

    gate_golden_model #(
        .WIDTH(WIDTH)
    ) u_golden (
        .op_sel_i  (2'(OP_SEL)),
        .a_i       (A),
        .b_i       (B),
        .expected_o(expected)
    );

    assign accept   = in_valid && (state_q == RUN);
    assign mismatch = (Result != expected);
    assign exit_ok  = (coverage_q == 4'hF) && ({1'b0, sample_cnt_q} >= MIN_CMP);
    assign combo    = {A[0], B[0]};

    // One-hot decode of the low-bit input combination.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cov
            assign cov_hit[gi] = (combo == 2'(gi));
        end
    endgenerate

    // Next-state logic; a start out of IDLE/DONE/FAIL also clears the statistics.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                // A stopping mismatch outranks a simultaneous completion.
                if ((STOP_ON_ERR != 0) && accept && mismatch) begin
                    state_d = FAIL;
                end else if (exit_ok) begin
                    state_d = DONE;
                end
            end
            DONE, FAIL: begin
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Statistics update on each accepted vector, saturating at all-ones.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_count_d  = err_count_q;
        coverage_d   = coverage_q;
        err_flag_d   = 1'b0;
        if (clear) begin
            sample_cnt_d = '0;
            err_count_d  = '0;
            coverage_d   = '0;
        end else if (accept) begin
            if (sample_cnt_q != CNT_MAX) begin
                sample_cnt_d = sample_cnt_q + 1'b1;
            end
            if (mismatch && (err_count_q != CNT_MAX)) begin
                err_count_d = err_count_q + 1'b1;
            end
            coverage_d = coverage_q | cov_hit;
            err_flag_d = mismatch;
        end
    end

    // State and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            err_count_q  <= '0;
            coverage_q   <= '0;
            err_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            err_count_q  <= err_count_d;
            coverage_q   <= coverage_d;
            err_flag_q   <= err_flag_d;
        end
    end

    assign in_ready   = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE) || (state_q == FAIL);
    assign pass       = (state_q == DONE) && (err_count_q == '0);
    assign err_flag   = err_flag_q;
    assign err_count  = err_count_q;
    assign sample_cnt = sample_cnt_q;
    assign coverage   = coverage_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench: three checker instances (default, stop-on-error, 3-bit
// counters) share the vector bus; only the started instance accepts.
module tb_gate_response_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       A = 1'b0, B = 1'b0, Result = 1'b0;
    logic [2:0] start = 3'b000;

    logic [2:0] rdy, busy, done, pass, ef;
    logic [7:0] sc0, ec0, sc1, ec1;
    logic [2:0] sc2, ec2;
    logic [3:0] cov0, cov1, cov2;

    always #5 clk = ~clk;

    gate_response_checker u0 (
        .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .in_ready(rdy[0]),
        .A(A), .B(B), .Result(Result), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_flag(ef[0]), .err_count(ec0), .sample_cnt(sc0), .coverage(cov0)
    );

    gate_response_checker #(.STOP_ON_ERR(1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .in_ready(rdy[1]),
        .A(A), .B(B), .Result(Result), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_flag(ef[1]), .err_count(ec1), .sample_cnt(sc1), .coverage(cov1)
    );

    gate_response_checker #(.CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid), .in_ready(rdy[2]),
        .A(A), .B(B), .Result(Result), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_flag(ef[2]), .err_count(ec2), .sample_cnt(sc2), .coverage(cov2)
    );

    typedef struct {
        int         id;
        logic       ef;
        logic [7:0] sc;
        logic [7:0] ec;
        logic [3:0] cov;
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] m_sc[3];
    logic [7:0] m_ec[3];
    logic [3:0] m_cov[3];
    logic [2:0] pend = 3'b000;

    function automatic logic [7:0] get_sc(int id);
        case (id)
            0: return sc0;
            1: return sc1;
            default: return {5'd0, sc2};
        endcase
    endfunction

    function automatic logic [7:0] get_ec(int id);
        case (id)
            0: return ec0;
            1: return ec1;
            default: return {5'd0, ec2};
        endcase
    endfunction

    function automatic logic [3:0] get_cov(int id);
        case (id)
            0: return cov0;
            1: return cov1;
            default: return cov2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear(input int id);
        m_sc[id]  = 8'd0;
        m_ec[id]  = 8'd0;
        m_cov[id] = 4'd0;
    endtask

    task automatic do_start(input int id);
        start[id] = 1'b1;
        tick();
        start[id] = 1'b0;
        model_clear(id);
    endtask

    // Drive one vector for a cycle; push the expected response if it should be taken.
    task automatic send(input int id, input logic a, input logic b, input logic res,
                        input bit exp_acc);
        exp_t       e;
        logic       mism;
        logic [7:0] maxv;
        A        = a;
        B        = b;
        Result   = res;
        in_valid = 1'b1;
        if (exp_acc) begin
            maxv = (id == 2) ? 8'd7 : 8'd255;
            mism = (res != (a & b));
            if (m_sc[id] != maxv) m_sc[id] = m_sc[id] + 8'd1;
            if (mism && (m_ec[id] != maxv)) m_ec[id] = m_ec[id] + 8'd1;
            m_cov[id] = m_cov[id] | (4'b0001 << {a, b});
            e.id  = id;
            e.ef  = mism;
            e.sc  = m_sc[id];
            e.ec  = m_ec[id];
            e.cov = m_cov[id];
            q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        A        = 1'bx;
        B        = 1'bx;
        Result   = 1'bx;
    endtask

    task automatic chk_out(input string tag, input int id, input logic e_done,
                           input logic e_pass, input logic e_busy, input logic [7:0] e_sc,
                           input logic [7:0] e_ec, input logic [3:0] e_cov);
        $display("check %s on u%0d: done=%0b pass=%0b busy=%0b sc=%0d ec=%0d cov=%b",
                 tag, id, done[id], pass[id], busy[id], get_sc(id), get_ec(id), get_cov(id));
        chk({tag, "_done"}, 32'(done[id]), 32'(e_done));
        chk({tag, "_pass"}, 32'(pass[id]), 32'(e_pass));
        chk({tag, "_busy"}, 32'(busy[id]), 32'(e_busy));
        chk({tag, "_ready"}, 32'(rdy[id]), 32'(e_busy));
        chk({tag, "_sample_cnt"}, 32'(get_sc(id)), 32'(e_sc));
        chk({tag, "_err_count"}, 32'(get_ec(id)), 32'(e_ec));
        chk({tag, "_coverage"}, 32'(get_cov(id)), 32'(e_cov));
    endtask

    // Monitor: one cycle after each accept, pop the scoreboard and compare.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (pend[i]) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_accept: u%0d accepted with empty scoreboard at %0t",
                             i, $time);
                end else begin
                    e = q.pop_front();
                    $display("txn u%0d: err_flag=%0b sc=%0d ec=%0d cov=%b (exp %0b %0d %0d %b)",
                             i, ef[i], get_sc(i), get_ec(i), get_cov(i), e.ef, e.sc, e.ec, e.cov);
                    chk("accept_instance", 32'(i), 32'(e.id));
                    chk("txn_err_flag", 32'(ef[i]), 32'(e.ef));
                    chk("txn_sample_cnt", 32'(get_sc(i)), 32'(e.sc));
                    chk("txn_err_count", 32'(get_ec(i)), 32'(e.ec));
                    chk("txn_coverage", 32'(get_cov(i)), 32'(e.cov));
                end
            end else begin
                chk("err_flag_idle", 32'(ef[i]), 32'd0);
            end
        end
        pend = rdy & {3{in_valid}} & {3{~rst}};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) model_clear(i);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_out("reset", 0, 0, 0, 0, 8'd0, 8'd0, 4'h0);

        // 1: full AND truth table, all correct
        do_start(0);
        send(0, 0, 0, 0, 1);
        send(0, 0, 1, 0, 1);
        send(0, 1, 0, 0, 1);
        send(0, 1, 1, 1, 1);
        tick();
        chk_out("t1", 0, 1, 1, 0, 8'd4, 8'd0, 4'hF);

        // 2: restart from DONE clears; 11 answered with 0
        do_start(0);
        chk_out("t2_start", 0, 0, 0, 1, 8'd0, 8'd0, 4'h0);
        send(0, 0, 0, 0, 1);
        send(0, 0, 1, 0, 1);
        send(0, 1, 0, 0, 1);
        send(0, 1, 1, 0, 1);
        tick();
        chk_out("t2", 0, 1, 0, 0, 8'd4, 8'd1, 4'hF);

        // 3: stop-on-error, second vector bad, later vectors ignored
        do_start(1);
        send(1, 0, 0, 0, 1);
        send(1, 0, 1, 1, 1);
        send(1, 1, 0, 0, 0);
        send(1, 1, 1, 1, 0);
        chk_out("t3", 1, 1, 0, 0, 8'd2, 8'd1, 4'b0011);

        // 4: only 00 ten times stays in RUN, then complete coverage
        do_start(0);
        repeat (10) send(0, 0, 0, 0, 1);
        tick();
        chk_out("t4a", 0, 0, 0, 1, 8'd10, 8'd0, 4'b0001);
        send(0, 0, 1, 0, 1);
        send(0, 1, 0, 0, 1);
        send(0, 1, 1, 1, 1);
        tick();
        chk_out("t4b", 0, 1, 1, 0, 8'd13, 8'd0, 4'hF);

        // 5: 3-bit counters saturate at 7
        do_start(2);
        repeat (9) send(2, 0, 0, 1, 1);
        tick();
        chk_out("t5a", 2, 0, 0, 1, 8'd7, 8'd7, 4'b0001);
        send(2, 0, 1, 1, 1);
        send(2, 1, 0, 1, 1);
        send(2, 1, 1, 0, 1);
        tick();
        chk_out("t5b", 2, 1, 0, 0, 8'd7, 8'd7, 4'hF);

        // 6: reset mid-run beats start and a valid vector on the same edge
        do_start(0);
        send(0, 0, 0, 0, 1);
        rst      = 1'b1;
        start[0] = 1'b1;
        in_valid = 1'b1;
        A        = 1'b1;
        B        = 1'b1;
        Result   = 1'b1;
        tick();
        rst      = 1'b0;
        start[0] = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) model_clear(i);
        chk_out("t6_rst_u0", 0, 0, 0, 0, 8'd0, 8'd0, 4'h0);
        chk_out("t6_rst_u1", 1, 0, 0, 0, 8'd0, 8'd0, 4'h0);
        chk_out("t6_rst_u2", 2, 0, 0, 0, 8'd0, 8'd0, 4'h0);
        do_start(0);
        chk_out("t6_start", 0, 0, 0, 1, 8'd0, 8'd0, 4'h0);
        send(0, 1, 1, 1, 1);
        tick();
        chk_out("t6_run", 0, 0, 0, 1, 8'd1, 8'd0, 4'b1000);

        tick();
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
